// File: rtl/shift_sum_pkg.sv
// Shared state encoding and datapath widths for the shift_sum sequencer.
package shift_sum_pkg;

    localparam int LANES  = 8;
    localparam int DATA_W = 8;
    localparam int SUM_W  = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_HOLD   = 3'd4
    } state_e;

endpackage

// File: rtl/shift_sum_round.sv
// Rounds the adder_tree sum to 8 bits as sum[15:8] + sum[7].
// Build with SHIFT_SUM_SAT_EN defined to saturate at 8'hFF instead of wrapping.
module shift_sum_round
    import shift_sum_pkg::*;
(
    input  logic [SUM_W-1:0]  sum_i,
    output logic [DATA_W-1:0] rounded_o
);

    logic [DATA_W:0] sum_rnd;

    assign sum_rnd = {1'b0, sum_i[15:8]} + {{DATA_W{1'b0}}, sum_i[7]};

`ifdef SHIFT_SUM_SAT_EN
    logic unused_lsbs;
    assign unused_lsbs = ^sum_i[6:0];
    assign rounded_o   = ((|sum_i[31:16]) || sum_rnd[DATA_W]) ? {DATA_W{1'b1}}
                                                             : sum_rnd[DATA_W-1:0];
`else
    // Legacy behaviour: carry out of the rounding add and the upper sum bits are dropped.
    logic unused_bits;
    assign unused_bits = ^{sum_i[31:16], sum_i[6:0], sum_rnd[DATA_W]};
    assign rounded_o   = sum_rnd[DATA_W-1:0];
`endif

endmodule

// File: rtl/shift_sum_ctrl.sv
// Frame sequencer for the 8-lane shifter + adder_tree: load, stream DEPTH samples,
// drain ADD_LAT cycles, then hold the rounded sum on a valid/ready port (SHIFT_SUM_SAT_EN selects saturation).
//
// state    | meaning
// IDLE     | waiting for start
// LOAD     | one-cycle shifter reload pulse
// STREAM   | DEPTH cycles of shift_en + in_valid
// DRAIN    | ADD_LAT cycles waiting out the adder pipeline
// HOLD     | result valid until result_ready
module shift_sum_ctrl
    import shift_sum_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int ADD_LAT = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              shift_load_o,
    output logic              shift_en_o,
    output logic              in_valid_o,
    input  logic [SUM_W-1:0]  sum_i,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic [7:0]        frame_cnt_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    // The same counter times DRAIN, so it must reach ADD_LAT-1 even for a tiny DEPTH.
    localparam int CTR_W = (CNT_W > 4) ? CNT_W : 4;

    state_e            state_q, state_d;
    logic [CTR_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] rounded;
    logic              valid_q, valid_d;
    logic [7:0]        frame_q, frame_d;

    shift_sum_round u_round (
        .sum_i     (sum_i),
        .rounded_o (rounded)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            frame_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            frame_q  <= frame_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        valid_d  = valid_q;
        frame_d  = frame_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_STREAM;
                cnt_d   = '0;
            end
            S_STREAM: begin
                if (cnt_q == CTR_W'(DEPTH - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CTR_W'(ADD_LAT - 1)) begin
                    state_d  = S_HOLD;
                    cnt_d    = '0;
                    result_d = rounded;
                    valid_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                // Start only counts together with the handshake; otherwise it is dropped.
                if (result_ready_i) begin
                    frame_d = frame_q + 8'd1;
                    valid_d = 1'b0;
                    state_d = start_i ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign busy_o         = (state_q != S_IDLE);
    assign shift_load_o   = (state_q == S_LOAD);
    assign shift_en_o     = (state_q == S_STREAM);
    assign in_valid_o     = (state_q == S_STREAM);
    assign result_o       = result_q;
    assign result_valid_o = valid_q;
    assign frame_cnt_o    = frame_q;

endmodule
